// File: rtl/serial_frame_sync.sv
// serial_frame_sync: serial frame aligner and deserializer.
// It hunts for SYNC_WORD in the incoming bit stream, confirms it over LOCK_CNT
// frames, and then emits the payload as DATA_W-bit words. It rides through
// isolated sync errors and drops lock after MISS_CNT consecutive misses.
module serial_frame_sync #(
  parameter int unsigned SYNC_W          = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hB8,
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned WORDS_PER_FRAME = 4,
  parameter int unsigned LOCK_CNT        = 2,
  parameter int unsigned MISS_CNT        = 3
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_data_in,
  input  logic              I_data_en,
  output logic [DATA_W-1:0] O_data_word,
  output logic              O_word_vld,
  output logic              O_word_sof,
  output logic              O_lock,
  output logic              O_sync_err
);

  localparam int unsigned FRAME_LEN = SYNC_W + WORDS_PER_FRAME * DATA_W;
  localparam int unsigned POS_W     = $clog2(FRAME_LEN);
  localparam int unsigned BIT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned CONF_W    = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W    = $clog2(MISS_CNT + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_t;

  state_t              state, state_n;
  logic [SYNC_W-1:0]   sr, sr_n, sr_shift;
  logic [POS_W-1:0]    pos, pos_n, pos_inc;
  logic [BIT_W-1:0]    bit_idx, bit_idx_n;
  logic [CONF_W-1:0]   confirm, confirm_n;
  logic [MISS_W-1:0]   miss, miss_n;
  logic [DATA_W-1:0]   word_sr, word_sr_n, word_shift;
  logic [DATA_W-1:0]   data_word_n;
  logic                word_vld_n, word_sof_n, sync_err_n, lock_n;
  logic                sync_match, sync_check;

  assign sr_shift   = {sr[SYNC_W-2:0], I_data_in};
  assign word_shift = {word_sr[DATA_W-2:0], I_data_in};
  assign sync_match = (sr_shift == SYNC_WORD);
  assign sync_check = (pos == POS_W'(SYNC_W - 1));
  assign pos_inc    = (pos == POS_W'(FRAME_LEN - 1)) ? '0 : pos + 1'b1;

  // State, counters, shift registers and registered outputs.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state       <= HUNT;
      sr          <= '0;
      pos         <= '0;
      bit_idx     <= '0;
      confirm     <= '0;
      miss        <= '0;
      word_sr     <= '0;
      O_data_word <= '0;
      O_word_vld  <= 1'b0;
      O_word_sof  <= 1'b0;
      O_sync_err  <= 1'b0;
      O_lock      <= 1'b0;
    end else begin
      state       <= state_n;
      sr          <= sr_n;
      pos         <= pos_n;
      bit_idx     <= bit_idx_n;
      confirm     <= confirm_n;
      miss        <= miss_n;
      word_sr     <= word_sr_n;
      O_data_word <= data_word_n;
      O_word_vld  <= word_vld_n;
      O_word_sof  <= word_sof_n;
      O_sync_err  <= sync_err_n;
      O_lock      <= lock_n;
    end
  end

  // Hunt/verify/lock sequencing and payload deserialization for each en-bit.
  always_comb begin
    state_n     = state;
    sr_n        = sr;
    pos_n       = pos;
    bit_idx_n   = bit_idx;
    confirm_n   = confirm;
    miss_n      = miss;
    word_sr_n   = word_sr;
    data_word_n = O_data_word;
    word_vld_n  = 1'b0;
    word_sof_n  = 1'b0;
    sync_err_n  = 1'b0;

    if (I_data_en) begin
      sr_n = sr_shift;
      unique case (state)
        HUNT: begin
          pos_n = '0;
          if (sync_match) begin
            pos_n     = POS_W'(SYNC_W);
            confirm_n = CONF_W'(1);
            bit_idx_n = '0;
            miss_n    = '0;
            state_n   = (LOCK_CNT == 1) ? LOCK : VERIFY;
          end
        end
        VERIFY: begin
          pos_n = pos_inc;
          if (sync_check) begin
            if (sync_match) begin
              if (int'(confirm) + 1 >= int'(LOCK_CNT)) begin
                confirm_n = CONF_W'(LOCK_CNT);
                bit_idx_n = '0;
                miss_n    = '0;
                state_n   = LOCK;
              end else begin
                confirm_n = confirm + 1'b1;
              end
            end else begin
              confirm_n = '0;
              state_n   = HUNT;
            end
          end
        end
        LOCK: begin
          pos_n = pos_inc;
          if (pos >= POS_W'(SYNC_W)) begin
            word_sr_n = word_shift;
            if (bit_idx == BIT_W'(DATA_W - 1)) begin
              bit_idx_n   = '0;
              data_word_n = word_shift;
              word_vld_n  = 1'b1;
              word_sof_n  = (pos == POS_W'(SYNC_W + DATA_W - 1));
            end else begin
              bit_idx_n = bit_idx + 1'b1;
            end
          end else if (sync_check) begin
            bit_idx_n = '0;
            if (sync_match) begin
              miss_n = '0;
            end else begin
              sync_err_n = 1'b1;
              if (int'(miss) + 1 >= int'(MISS_CNT)) begin
                miss_n    = '0;
                confirm_n = '0;
                state_n   = HUNT;
              end else begin
                miss_n = miss + 1'b1;
              end
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end

    lock_n = (state_n == LOCK);
  end

endmodule

// File: tb/tb_serial_frame_sync.sv
// tb_serial_frame_sync: table-driven bench for serial_frame_sync.
// Each case builds a list of {input bit, enable, expected outputs} records
// from frame layout and the expected word/error positions, then plays it.
module tb_serial_frame_sync;

  logic       I_clk = 1'b0;
  logic       I_rst;
  logic       I_data_in;
  logic       I_data_en;
  logic [7:0] O_data_word;
  logic       O_word_vld;
  logic       O_word_sof;
  logic       O_lock;
  logic       O_sync_err;

  int total = 0;
  int bad   = 0;

  serial_frame_sync dut (
    .I_clk       (I_clk),
    .I_rst       (I_rst),
    .I_data_in   (I_data_in),
    .I_data_en   (I_data_en),
    .O_data_word (O_data_word),
    .O_word_vld  (O_word_vld),
    .O_word_sof  (O_word_sof),
    .O_lock      (O_lock),
    .O_sync_err  (O_sync_err)
  );

  // Free-running 100 MHz clock.
  always #5 I_clk = ~I_clk;

  typedef struct {
    logic       din;
    logic       en;
    logic       expVld;
    logic       expSof;
    logic       expErr;
    logic       expLock;
    logic [7:0] expWord;
  } vec_t;

  vec_t       vecs[$];
  int         vldK[$];
  logic [7:0] vldW[$];
  logic       vldS[$];
  int         errK[$];
  logic [7:0] syncs[$];
  logic [7:0] payload[4];
  int         bitK;
  logic [7:0] curWord;

  task automatic applyStimulus(input logic din, input logic en);
    I_data_in = din;
    I_data_en = en;
    @(posedge I_clk);
    #1;
  endtask

  task automatic checkOutput(input string what, input int idx,
                             input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s[%0d]: got %0h expected %0h", what, idx, act, exp);
    end
  endtask

  task automatic checkAllZero(input string what, input int idx);
    checkOutput({what, ".word"}, idx, O_data_word, 8'h00);
    checkOutput({what, ".vld"},  idx, {7'b0, O_word_vld}, 8'h00);
    checkOutput({what, ".sof"},  idx, {7'b0, O_word_sof}, 8'h00);
    checkOutput({what, ".lock"}, idx, {7'b0, O_lock},     8'h00);
    checkOutput({what, ".err"},  idx, {7'b0, O_sync_err}, 8'h00);
  endtask

  task automatic doReset();
    I_rst = 1'b1;
    applyStimulus(1'b1, 1'b1);
    I_rst = 1'b0;
    checkAllZero("reset", 0);
  endtask

  // Expected words of frames firstF..lastF, counted in en-bits from offset.
  task automatic setWords(input int offset, input int firstF, input int lastF);
    for (int f = firstF; f <= lastF; f++) begin
      for (int n = 0; n < 4; n++) begin
        vldK.push_back(offset + 40 * f + 15 + 8 * n);
        vldW.push_back(payload[n]);
        vldS.push_back(n == 0);
      end
    end
  endtask

  task automatic clearLists();
    vecs.delete();
    vldK.delete();
    vldW.delete();
    vldS.delete();
    errK.delete();
    syncs.delete();
    bitK    = 0;
    curWord = 8'h00;
  endtask

  task automatic addBit(input logic b, input int gap, input int lockOn, input int lockOff);
    vec_t v;
    v.din    = b;
    v.en     = 1'b1;
    v.expVld = 1'b0;
    v.expSof = 1'b0;
    v.expErr = 1'b0;
    foreach (vldK[i]) begin
      if (vldK[i] == bitK) begin
        v.expVld = 1'b1;
        v.expSof = vldS[i];
        curWord  = vldW[i];
      end
    end
    foreach (errK[i]) begin
      if (errK[i] == bitK) v.expErr = 1'b1;
    end
    v.expLock = (lockOn >= 0) && (bitK >= lockOn) && ((lockOff < 0) || (bitK < lockOff));
    v.expWord = curWord;
    vecs.push_back(v);
    for (int g = 0; g < gap; g++) begin
      v.din    = ~b;
      v.en     = 1'b0;
      v.expVld = 1'b0;
      v.expSof = 1'b0;
      v.expErr = 1'b0;
      vecs.push_back(v);
    end
    bitK++;
  endtask

  task automatic addByte(input logic [7:0] value, input int gap, input int lockOn, input int lockOff);
    for (int b = 7; b >= 0; b--) addBit(value[b], gap, lockOn, lockOff);
  endtask

  task automatic buildFrames(input int junkLen, input int gap, input int lockOn, input int lockOff);
    logic [4:0] junk;
    junk = 5'b10110;
    for (int i = 0; i < junkLen; i++) addBit(junk[4 - i], gap, lockOn, lockOff);
    foreach (syncs[f]) begin
      addByte(syncs[f], gap, lockOn, lockOff);
      for (int n = 0; n < 4; n++) addByte(payload[n], gap, lockOn, lockOff);
    end
  endtask

  task automatic runVecs(input string what);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].din, vecs[i].en);
      checkOutput({what, ".vld"},  i, {7'b0, O_word_vld}, {7'b0, vecs[i].expVld});
      checkOutput({what, ".sof"},  i, {7'b0, O_word_sof}, {7'b0, vecs[i].expSof});
      checkOutput({what, ".err"},  i, {7'b0, O_sync_err}, {7'b0, vecs[i].expErr});
      checkOutput({what, ".lock"}, i, {7'b0, O_lock},     {7'b0, vecs[i].expLock});
      checkOutput({what, ".word"}, i, O_data_word,        vecs[i].expWord);
    end
  endtask

  // Three good frames, optional junk prefix and enable gaps.
  task automatic runGoodCase(input string what, input int junkLen, input int gap);
    doReset();
    clearLists();
    repeat (3) syncs.push_back(8'hB8);
    setWords(junkLen, 1, 2);
    buildFrames(junkLen, gap, junkLen + 47, -1);
    runVecs(what);
  endtask

  initial begin
    payload[0] = 8'h11;
    payload[1] = 8'h22;
    payload[2] = 8'h33;
    payload[3] = 8'h44;
    I_rst      = 1'b1;
    I_data_in  = 1'b0;
    I_data_en  = 1'b0;

    $display("[TB] reset hold");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i[0], 1'b1);
      checkAllZero("rst_hold", i);
    end
    I_rst = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkAllZero("rst_release", 0);

    $display("[TB] no sync present");
    for (int i = 0; i < 80; i++) begin
      applyStimulus(~i[0], 1'b1);
      checkOutput("nosync.lock", i, {7'b0, O_lock},     8'h00);
      checkOutput("nosync.vld",  i, {7'b0, O_word_vld}, 8'h00);
    end

    $display("[TB] lock and data");
    runGoodCase("lock", 0, 0);

    $display("[TB] misalignment");
    runGoodCase("misalign", 5, 0);

    $display("[TB] gapped enable");
    runGoodCase("gapped", 0, 2);

    $display("[TB] flywheel");
    doReset();
    clearLists();
    syncs.push_back(8'hB8);
    syncs.push_back(8'hB8);
    syncs.push_back(8'h00);
    syncs.push_back(8'hB8);
    setWords(0, 1, 3);
    errK.push_back(87);
    buildFrames(0, 0, 47, -1);
    runVecs("flywheel");

    $display("[TB] loss of lock");
    doReset();
    clearLists();
    syncs.push_back(8'hB8);
    syncs.push_back(8'hB8);
    syncs.push_back(8'h00);
    syncs.push_back(8'h00);
    syncs.push_back(8'h00);
    syncs.push_back(8'hB8);
    setWords(0, 1, 3);
    errK.push_back(87);
    errK.push_back(127);
    errK.push_back(167);
    buildFrames(0, 0, 47, 167);
    runVecs("loss");

    $display("[TB] reset mid-frame");
    doReset();
    clearLists();
    syncs.push_back(8'hB8);
    syncs.push_back(8'hB8);
    setWords(0, 1, 1);
    vldK.push_back(95);
    vldW.push_back(8'h11);
    vldS.push_back(1'b1);
    buildFrames(0, 0, 47, -1);
    addByte(8'hB8, 0, 47, -1);
    addByte(8'h11, 0, 47, -1);
    for (int b = 7; b >= 4; b--) addBit(payload[1][b], 0, 47, -1);
    runVecs("midrst_pre");
    I_rst = 1'b1;
    applyStimulus(1'b0, 1'b1);
    I_rst = 1'b0;
    checkAllZero("midrst", 0);
    clearLists();
    syncs.push_back(8'hB8);
    syncs.push_back(8'hB8);
    setWords(0, 1, 1);
    buildFrames(0, 0, 47, -1);
    runVecs("midrst_relock");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
